// File: rtl/ice_sl_arbiter_if.sv
// rtl/ice_sl_arbiter_if.sv - request/grant/tail bundle between interface blocks and the slave bus arbiter
interface ice_sl_arbiter_if #(
  parameter int NUM_DEV = 7
);
  logic [NUM_DEV-1:0] sl_arb_request;
  logic [NUM_DEV-1:0] sl_arb_grant;
  logic               sl_latch_tail;

  // Requesting interface blocks drive requests and the frame tail
  modport master (
    output sl_arb_request,
    output sl_latch_tail,
    input  sl_arb_grant
  );

  // The arbiter consumes requests/tail and drives the grant vector
  modport slave (
    input  sl_arb_request,
    input  sl_latch_tail,
    output sl_arb_grant
  );
endinterface

// File: rtl/ice_sl_arbiter.sv
// rtl/ice_sl_arbiter.sv - round-robin slave output bus arbiter with frame hold, drain wait and watchdog
module ice_sl_arbiter #(
  parameter int NUM_DEV = 7,
  parameter int OWNER_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  ice_sl_arbiter_if.slave    bus,
  input  logic               tx_idle,
  input  logic [15:0]        timeout_limit,
  output logic               arb_busy,
  output logic [OWNER_W-1:0] arb_owner,
  output logic               timeout_evt,
  output logic [7:0]         grant_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [NUM_DEV-1:0] GRANT_ONE = NUM_DEV'(1);
  localparam logic [OWNER_W-1:0] OWNER_RST = OWNER_W'(NUM_DEV - 1);

  state_e             state_q, state_d;
  logic [NUM_DEV-1:0] grant_q, grant_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [7:0]         count_q, count_d;
  logic [15:0]        wd_q, wd_d;
  logic               evt_q, evt_d;
  logic               busy_q, busy_d;

  logic               pick_valid;
  logic [OWNER_W-1:0] pick_idx;
  logic [OWNER_W-1:0] cand;
  logic               tail_end;
  logic               abort_end;
  logic               wd_hit;

  // Round-robin pick: first active request scanning upward from the last owner
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = owner_q;
    cand       = owner_q;
    for (int i = 1; i <= NUM_DEV; i++) begin
      cand = OWNER_W'((int'(owner_q) + i) % NUM_DEV);
      if (!pick_valid && bus.sl_arb_request[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Frame-end conditions; the watchdog only fires with a nonzero limit
  always_comb begin
    tail_end  = bus.sl_latch_tail;
    abort_end = ~|(bus.sl_arb_request & grant_q);
    wd_hit    = (timeout_limit != 16'd0) && (wd_q == timeout_limit);
  end

  // Next-state and registered-output computation for the IDLE/GRANT/DRAIN machine
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    count_d = count_q;
    wd_d    = wd_q;
    evt_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_valid && tx_idle) begin
          grant_d = GRANT_ONE << pick_idx;
          owner_d = pick_idx;
          count_d = count_q + 8'd1;
          wd_d    = 16'd0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (wd_q != 16'hFFFF) begin
          wd_d = wd_q + 16'd1;
        end
        if (tail_end || abort_end || wd_hit) begin
          state_d = ST_DRAIN;
          grant_d = '0;
          // A tail in the same cycle wins: the frame ended normally
          evt_d   = wd_hit && !tail_end;
        end
      end
      ST_DRAIN: begin
        grant_d = '0;
        if (tx_idle) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops the grant without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= OWNER_RST;
      count_q <= 8'd0;
      wd_q    <= 16'd0;
      evt_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      count_q <= count_d;
      wd_q    <= wd_d;
      evt_q   <= evt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sl_arb_grant = grant_q;
  assign arb_busy         = busy_q;
  assign arb_owner        = owner_q;
  assign timeout_evt      = evt_q;
  assign grant_count      = count_q;

endmodule
